arithmetic_datapath: RTL and testbench

- Register file and ALU for the arithmetic unit: word registers A, B, C, D plus combinational sum/AND logic.
- Executes the one-cycle micro-operation strobes issued by the arithmetic sequencing controller.
- Returns status bits (B sign, C LSB, D sign) that the controller uses to branch.
- Sits between the memory-read path and the controller; all arithmetic state lives here.

---
 rtl/arithmetic_datapath_pkg.sv | 14 +
 rtl/ones_complement_adder.sv | 18 +
 rtl/arithmetic_datapath.sv | 135 +++++++++++++
 tb/tb_arithmetic_datapath.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arithmetic_datapath_pkg.sv
// Shared word geometry and strobe helpers for the arithmetic unit datapath.
// Bit 0 is the sign/MSB and bit WORD_W-1 the LSB, matching the controller's view.
package arithmetic_datapath_pkg;

    localparam int WORD_W   = 31;
    localparam int SIGN_IDX = 0;
    localparam int LSB_IDX  = WORD_W - 1;

    // True when two or more strobes aimed at one register fire together.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/ones_complement_adder.sv
// Combinational WIDTH-bit ones'-complement adder: carry out of the MSB is
// folded back into the LSB once; a carry from that second add is dropped.
module ones_complement_adder #(
    parameter int WIDTH = 31
) (
    input  logic [0:WIDTH-1] i_a,
    input  logic [0:WIDTH-1] i_b,
    output logic [0:WIDTH-1] o_sum
);

    logic [WIDTH:0]   w_raw;
    logic [WIDTH-1:0] w_wrapped;

    assign w_raw     = {1'b0, i_a} + {1'b0, i_b};
    assign w_wrapped = w_raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_raw[WIDTH]};
    assign o_sum     = w_wrapped;

endmodule

// File: rtl/arithmetic_datapath.sv
// Register file A/B/C/D and ALU for the arithmetic unit, driven by one-cycle
// micro-operation strobes; conflicting strobes on a register hold it and raise a sticky flag.
module arithmetic_datapath
    import arithmetic_datapath_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             do_clear_a,
    input  logic             do_clear_b,
    input  logic             do_clear_c,
    input  logic             do_not_a,
    input  logic             do_not_b,
    input  logic             do_sum,
    input  logic             do_and,
    input  logic             do_set_c_30,
    input  logic             do_left_shift_b,
    input  logic             do_left_shift_c,
    input  logic             do_left_shift_c29,
    input  logic             do_right_shift_bc,
    input  logic             do_move_c_to_a,
    input  logic             do_move_c_to_b,
    input  logic             do_move_b_to_c,
    input  logic             do_read_mem,
    input  logic [0:WIDTH-1] mem_read_data,
    input  logic             do_arr_c,
    input  logic [0:WIDTH-1] arr_data,
    input  logic             err_clear,
    output logic [0:WIDTH-1] reg_a,
    output logic [0:WIDTH-1] reg_b,
    output logic [0:WIDTH-1] reg_c,
    output logic [0:WIDTH-1] reg_d,
    output logic             reg_b_0,
    output logic             reg_c_30,
    output logic             reg_d_0,
    output logic             conflict_err
);

    logic [0:WIDTH-1] r_a, r_b, r_c, r_d;
    logic             r_err;

    logic [7:0]       w_a_sel, w_b_sel, w_c_sel;
    logic             w_a_conf, w_b_conf, w_c_conf, w_conflict, w_rs_ok;
    logic [0:WIDTH-1] w_sum;
    logic [0:WIDTH-1] w_a_nxt, w_b_nxt, w_c_nxt;
    logic             w_err_nxt;

    ones_complement_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_sum)
    );

    assign w_a_sel = {5'b0, do_clear_a, do_not_a, do_move_c_to_a};
    assign w_b_sel = {3'b0, do_clear_b, do_not_b, do_left_shift_b,
                      do_right_shift_bc, do_move_c_to_b};
    assign w_c_sel = {do_clear_c, do_sum, do_and, do_set_c_30, do_left_shift_c,
                      do_right_shift_bc, do_move_b_to_c, do_arr_c};

    assign w_a_conf   = multi_hot(w_a_sel);
    assign w_b_conf   = multi_hot(w_b_sel);
    assign w_c_conf   = multi_hot(w_c_sel);
    assign w_conflict = w_a_conf | w_b_conf | w_c_conf;
    // The {B,C} shift is all-or-nothing: a clash on either half cancels both.
    assign w_rs_ok    = do_right_shift_bc & ~w_b_conf & ~w_c_conf;

    always_comb begin
        w_a_nxt = r_a;
        if (!w_a_conf) begin
            if (do_clear_a)          w_a_nxt = '0;
            else if (do_not_a)       w_a_nxt = ~r_a;
            else if (do_move_c_to_a) w_a_nxt = r_c;
        end
    end

    always_comb begin
        w_b_nxt = r_b;
        if (!w_b_conf) begin
            if (do_clear_b)             w_b_nxt = '0;
            else if (do_not_b)          w_b_nxt = ~r_b;
            else if (do_left_shift_b)   w_b_nxt = {r_b[1:WIDTH-1], 1'b0};
            else if (w_rs_ok)           w_b_nxt = {r_b[0], r_b[0:WIDTH-2]};
            else if (do_move_c_to_b)    w_b_nxt = r_c;
        end
    end

    always_comb begin
        w_c_nxt = r_c;
        if (!w_c_conf) begin
            if (do_clear_c)             w_c_nxt = '0;
            else if (do_sum)            w_c_nxt = w_sum;
            else if (do_and)            w_c_nxt = r_a & r_b;
            else if (do_set_c_30)       w_c_nxt[LSB_IDX] = 1'b1;
            // Sign stays put; the c29 modifier turns the magnitude shift into a rotate.
            else if (do_left_shift_c)
                w_c_nxt = {r_c[0], r_c[2:WIDTH-1], do_left_shift_c29 & r_c[1]};
            else if (w_rs_ok)           w_c_nxt = {r_b[WIDTH-1], r_c[0:WIDTH-2]};
            else if (do_move_b_to_c)    w_c_nxt = r_b;
            else if (do_arr_c)          w_c_nxt = arr_data;
        end
    end

    always_comb begin
        w_err_nxt = r_err;
        if (w_conflict)     w_err_nxt = 1'b1;
        else if (err_clear) w_err_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_err <= 1'b0;
        end else begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_c   <= w_c_nxt;
            r_err <= w_err_nxt;
            if (do_read_mem) r_d <= mem_read_data;
        end
    end

    assign reg_a        = r_a;
    assign reg_b        = r_b;
    assign reg_c        = r_c;
    assign reg_d        = r_d;
    assign reg_b_0      = r_b[SIGN_IDX];
    assign reg_c_30     = r_c[LSB_IDX];
    assign reg_d_0      = r_d[SIGN_IDX];
    assign conflict_err = r_err;

endmodule

// File: tb/tb_arithmetic_datapath.sv
// Directed and randomized bench for arithmetic_datapath against an arithmetic-level model.
module tb_arithmetic_datapath;

    localparam int W = 31;
    localparam logic [30:0] MAG_MASK = 31'h3FFFFFFF;

    localparam int CLA = 0, CLB = 1, CLC = 2, NTA = 3, NTB = 4, SUM = 5, AND = 6,
                   SC30 = 7, LSB = 8, LSC = 9, LSC29 = 10, RS = 11, C2A = 12,
                   C2B = 13, B2C = 14, RDM = 15, ARR = 16, ERC = 17;

    localparam logic [17:0] S_CLA = 18'd1 << CLA, S_NTA = 18'd1 << NTA,
                            S_NTB = 18'd1 << NTB, S_SUM = 18'd1 << SUM,
                            S_AND = 18'd1 << AND, S_SC30 = 18'd1 << SC30,
                            S_LSC = 18'd1 << LSC, S_LSC29 = 18'd1 << LSC29,
                            S_RS = 18'd1 << RS, S_C2A = 18'd1 << C2A,
                            S_C2B = 18'd1 << C2B, S_B2C = 18'd1 << B2C,
                            S_RDM = 18'd1 << RDM, S_ARR = 18'd1 << ARR,
                            S_ERC = 18'd1 << ERC;

    logic clk = 1'b0;
    logic resetn;
    logic [17:0] stb;
    logic [0:W-1] mem_read_data, arr_data;
    logic [0:W-1] reg_a, reg_b, reg_c, reg_d;
    logic reg_b_0, reg_c_30, reg_d_0, conflict_err;

    logic [30:0] m_a, m_b, m_c, m_d;
    logic        m_err;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arithmetic_datapath #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn),
        .do_clear_a(stb[CLA]), .do_clear_b(stb[CLB]), .do_clear_c(stb[CLC]),
        .do_not_a(stb[NTA]), .do_not_b(stb[NTB]), .do_sum(stb[SUM]), .do_and(stb[AND]),
        .do_set_c_30(stb[SC30]), .do_left_shift_b(stb[LSB]), .do_left_shift_c(stb[LSC]),
        .do_left_shift_c29(stb[LSC29]), .do_right_shift_bc(stb[RS]),
        .do_move_c_to_a(stb[C2A]), .do_move_c_to_b(stb[C2B]), .do_move_b_to_c(stb[B2C]),
        .do_read_mem(stb[RDM]), .mem_read_data(mem_read_data),
        .do_arr_c(stb[ARR]), .arr_data(arr_data), .err_clear(stb[ERC]),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
        .reg_b_0(reg_b_0), .reg_c_30(reg_c_30), .reg_d_0(reg_d_0),
        .conflict_err(conflict_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_c = '0; m_d = '0; m_err = 1'b0;
    endtask

    // Register semantics in plain arithmetic: values are numbers, LSB is numeric bit 0.
    task automatic model_step();
        int na, nb, nc;
        logic conf, rs_ok;
        logic [30:0] a_n, b_n, c_n, sign, mag;
        logic [31:0] s;
        logic signed [61:0] pair;
        na = int'(stb[CLA]) + int'(stb[NTA]) + int'(stb[C2A]);
        nb = int'(stb[CLB]) + int'(stb[NTB]) + int'(stb[LSB]) + int'(stb[RS]) + int'(stb[C2B]);
        nc = int'(stb[CLC]) + int'(stb[SUM]) + int'(stb[AND]) + int'(stb[SC30]) +
             int'(stb[LSC]) + int'(stb[RS]) + int'(stb[B2C]) + int'(stb[ARR]);
        conf  = (na > 1) || (nb > 1) || (nc > 1);
        rs_ok = stb[RS] && nb == 1 && nc == 1;
        a_n = m_a; b_n = m_b; c_n = m_c;
        pair = $signed({m_b, m_c}) >>> 1;
        if (na == 1) begin
            if (stb[CLA])      a_n = 0;
            else if (stb[NTA]) a_n = ~m_a;
            else               a_n = m_c;
        end
        if (nb == 1) begin
            if (stb[CLB])      b_n = 0;
            else if (stb[NTB]) b_n = ~m_b;
            else if (stb[LSB]) b_n = m_b << 1;
            else if (stb[C2B]) b_n = m_c;
        end
        if (nc == 1) begin
            if (stb[CLC])       c_n = 0;
            else if (stb[SUM]) begin
                s = 32'(m_a) + 32'(m_b);
                if (s >= 32'h80000000) s = s - 32'h80000000 + 32'd1;
                c_n = s[30:0];
            end
            else if (stb[AND])  c_n = m_a & m_b;
            else if (stb[SC30]) c_n = m_c | 31'd1;
            else if (stb[LSC]) begin
                sign = m_c & 31'h40000000;
                mag  = m_c & MAG_MASK;
                c_n  = sign | ((mag << 1) & MAG_MASK) | (stb[LSC29] ? (mag >> 29) : 31'd0);
            end
            else if (stb[B2C])  c_n = m_b;
            else if (stb[ARR])  c_n = arr_data;
        end
        if (rs_ok) begin
            b_n = pair[61:31];
            c_n = pair[30:0];
        end
        m_a = a_n; m_b = b_n; m_c = c_n;
        if (stb[RDM]) m_d = mem_read_data;
        if (conf) m_err = 1'b1;
        else if (stb[ERC]) m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a"}, 32'(reg_a), 32'(m_a));
        chk({tag, ".b"}, 32'(reg_b), 32'(m_b));
        chk({tag, ".c"}, 32'(reg_c), 32'(m_c));
        chk({tag, ".d"}, 32'(reg_d), 32'(m_d));
        chk({tag, ".err"}, 32'(conflict_err), 32'(m_err));
        chk({tag, ".status"}, 32'({reg_b_0, reg_c_30, reg_d_0}),
            32'({m_b[30], m_c[0], m_d[30]}));
    endtask

    // Inputs change only at the falling edge; results are sampled at the next falling edge.
    task automatic cycle(input logic [17:0] s, input logic [30:0] arr, input logic [30:0] mem,
                         input string tag);
        stb = s; arr_data = arr; mem_read_data = mem;
        @(posedge clk);
        model_step();
        @(negedge clk);
        stb = '0;
        check_all(tag);
    endtask

    task automatic load_ab(input logic [30:0] a, input logic [30:0] b);
        cycle(S_ARR, a, 0, "ld");
        cycle(S_C2A, 0, 0, "ld");
        cycle(S_ARR, b, 0, "ld");
        cycle(S_C2B, 0, 0, "ld");
    endtask

    task automatic load_bc(input logic [30:0] b, input logic [30:0] c);
        cycle(S_ARR, b, 0, "ld");
        cycle(S_C2B, 0, 0, "ld");
        cycle(S_ARR, c, 0, "ld");
    endtask

    initial begin
        logic [17:0] rs;
        stb = '0; arr_data = '0; mem_read_data = '0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        resetn = 1'b1;

        // Asynchronous reset between edges
        load_ab(31'd5, 31'd0);
        cycle(S_ARR | S_RDM, 31'd6, 31'h7ABCDEF0, "preload");
        chk("pre_rst_a", 32'(reg_a), 32'd5);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        resetn = 1'b1;

        // End-around carry
        load_ab(31'h7FFFFFFE, 31'd5);
        cycle(S_SUM, 0, 0, "sum_eac");
        chk("sum_eac_const", 32'(reg_c), 32'h4);
        load_ab(31'd3, 31'd4);
        cycle(S_SUM, 0, 0, "sum_plain");
        chk("sum_plain_const", 32'(reg_c), 32'h7);

        // AND then move
        load_ab(31'h0F, 31'h3C);
        cycle(S_AND, 0, 0, "and");
        chk("and_const", 32'(reg_c), 32'h0C);
        cycle(S_C2B, 0, 0, "and_move");
        chk("and_move_const", 32'(reg_b), 32'h0C);

        // Left shift of C: rotate, zero-fill, modifier alone
        cycle(S_ARR, 31'h60000001, 0, "lsc_ld");
        cycle(S_LSC | S_LSC29, 0, 0, "lsc_rot");
        chk("lsc_rot_const", 32'(reg_c), 32'h40000003);
        cycle(S_ARR, 31'h60000001, 0, "lsc_ld");
        cycle(S_LSC, 0, 0, "lsc_zero");
        chk("lsc_zero_const", 32'(reg_c), 32'h40000002);
        cycle(S_LSC29, 0, 0, "lsc29_alone");
        chk("lsc29_alone_c", 32'(reg_c), 32'h40000002);
        chk("lsc29_alone_err", 32'(conflict_err), 32'd0);
        cycle(S_SC30, 0, 0, "set_c30");

        // Right shift and swap
        load_bc(31'h40000001, 31'd0);
        cycle(S_RS, 0, 0, "rshift");
        chk("rshift_b", 32'(reg_b), 32'h60000000);
        chk("rshift_c", 32'(reg_c), 32'h40000000);
        load_bc(31'd1, 31'd2);
        cycle(S_C2B | S_B2C, 0, 0, "swap");
        chk("swap_b", 32'(reg_b), 32'd2);
        chk("swap_c", 32'(reg_c), 32'd1);
        chk("swap_err", 32'(conflict_err), 32'd0);

        // Conflicts and sticky flag
        load_ab(31'd9, 31'd0);
        cycle(S_CLA | S_NTA | S_NTB, 0, 0, "conf_a");
        chk("conf_a_hold", 32'(reg_a), 32'd9);
        chk("conf_b_upd", 32'(reg_b), 32'h7FFFFFFF);
        chk("conf_err_set", 32'(conflict_err), 32'd1);
        cycle(S_ERC, 0, 0, "err_clr");
        chk("err_clr_const", 32'(conflict_err), 32'd0);
        cycle(S_ERC | S_CLA | S_C2A, 0, 0, "err_clr_conf");
        chk("err_clr_conf_const", 32'(conflict_err), 32'd1);
        load_bc(31'h40000001, 31'h12345);
        cycle(S_RS | S_C2B, 0, 0, "rs_conf_b");
        cycle(S_RS | S_SUM, 0, 0, "rs_conf_c");
        cycle(S_ERC, 0, 0, "err_clr2");

        // Random strobe mixes against the model
        for (int i = 0; i < 400; i++) begin
            rs = '0;
            for (int k = 0; k < 18; k++)
                if ($urandom_range(0, 6) == 0) rs[k] = 1'b1;
            cycle(rs, 31'($urandom), 31'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
